seq_detect_prog: RTL and testbench

Programmable serial bit-sequence detector. It is the parametrised successor to the fixed 5-bit pattern detector. Pattern value, pattern length and overlap mode are loaded at run time. It produces a registered one-cycle match pulse and a saturating match counter, and feeds protocol front-ends and test-pattern checkers in the same serial-IO domain.

---
 rtl/seqdet_pkg.sv | 17 +
 rtl/seqdet_sat_cnt.sv | 24 ++
 rtl/seq_detect_prog.sv | 115 +++++++++++
 tb/tb_seq_detect_prog.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/seqdet_pkg.sv
// Shared types and helpers for the programmable serial sequence detector.
package seqdet_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        ARM  = 2'd2
    } state_t;

    localparam int unsigned CNT_W_DEF = 8;
    localparam logic [CNT_W_DEF-1:0] CNT_MAX = '1;

    function automatic int unsigned len_width(input int unsigned max_len);
        return $clog2(max_len + 1);
    endfunction

endpackage

// File: rtl/seqdet_sat_cnt.sv
// Saturating match counter; clear wins over increment.
module seqdet_sat_cnt
    import seqdet_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/seq_detect_prog.sv
// Programmable serial bit-sequence detector with run-time pattern, length
// and overlap mode; registered match pulse and saturating match count.
module seq_detect_prog
    import seqdet_pkg::*;
#(
    parameter  int unsigned MAX_LEN = 8,
    parameter  int unsigned CNT_W   = 8,
    localparam int unsigned LEN_W   = len_width(MAX_LEN)
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               EN,
    input  logic               I,
    input  logic               LOAD,
    input  logic [MAX_LEN-1:0] PATTERN,
    input  logic [LEN_W-1:0]   LEN,
    input  logic               OVERLAP,
    input  logic               CLR_CNT,
    output logic               Z,
    output logic [CNT_W-1:0]   MATCH_CNT,
    output logic               CFG_ERR,
    output logic               ARMED
);

    localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);
    localparam logic [LEN_W-1:0] ONE_L     = LEN_W'(1);

    state_t             state;
    logic [MAX_LEN-1:0] pat;
    logic [LEN_W-1:0]   len;
    logic               ovl;
    logic [MAX_LEN-2:0] hist;
    logic [LEN_W-1:0]   fill;
    logic [LEN_W-1:0]   fill_nxt;

    logic [MAX_LEN-1:0] window;
    logic [MAX_LEN-1:0] mask;
    logic               len_ok;
    logic               sample;
    logic               hit;
    logic               match_ev;

    // The incoming bit joins the history so a match fires on the edge that samples it.
    always_comb begin
        window   = {hist, I};
        mask     = '0;
        for (int unsigned k = 0; k < MAX_LEN; k++) begin
            mask[k] = (k < 32'(len));
        end
        hit      = (((window ^ pat) & mask) == '0);
        len_ok   = (LEN != '0) && (LEN <= MAX_LEN_L);
        sample   = EN && !LOAD && ((state == FILL) || (state == ARM));
        match_ev = sample && (state == ARM) && hit;
        fill_nxt = fill + ONE_L;
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state   <= IDLE;
            pat     <= '0;
            len     <= '0;
            ovl     <= 1'b0;
            hist    <= '0;
            fill    <= '0;
            Z       <= 1'b0;
            CFG_ERR <= 1'b0;
        end else if (LOAD) begin
            pat     <= PATTERN;
            len     <= LEN;
            ovl     <= OVERLAP;
            hist    <= '0;
            fill    <= '0;
            Z       <= 1'b0;
            CFG_ERR <= !len_ok;
            if (!len_ok) begin
                state <= IDLE;
            end else if (LEN == ONE_L) begin
                state <= ARM;
            end else begin
                state <= FILL;
            end
        end else begin
            Z <= match_ev;
            if (sample) begin
                hist <= window[MAX_LEN-2:0];
                if (state == FILL) begin
                    fill <= fill_nxt;
                    if (fill_nxt == (len - ONE_L)) begin
                        state <= ARM;
                    end
                end else if (hit && !ovl) begin
                    // Non-overlap restart discards the history that produced the match.
                    hist <= '0;
                    fill <= '0;
                    if (len != ONE_L) begin
                        state <= FILL;
                    end
                end
            end
        end
    end

    assign ARMED = (state == ARM);

    seqdet_sat_cnt #(
        .CNT_W (CNT_W)
    ) u_cnt (
        .CLK   (CLK),
        .RST   (RST),
        .inc   (match_ev),
        .clr   (CLR_CNT),
        .count (MATCH_CNT)
    );

endmodule

// File: tb/tb_seq_detect_prog.sv
// Directed self-checking bench for seq_detect_prog (MAX_LEN=8, CNT_W=2).
module tb_seq_detect_prog;

    localparam int unsigned MAX_LEN = 8;
    localparam int unsigned CNT_W   = 2;

    logic             CLK;
    logic             RST;
    logic             EN;
    logic             I;
    logic             LOAD;
    logic [7:0]       PATTERN;
    logic [3:0]       LEN;
    logic             OVERLAP;
    logic             CLR_CNT;
    logic             Z;
    logic [CNT_W-1:0] MATCH_CNT;
    logic             CFG_ERR;
    logic             ARMED;

    int n_checks = 0;
    int n_fail   = 0;

    seq_detect_prog #(
        .MAX_LEN (MAX_LEN),
        .CNT_W   (CNT_W)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .EN        (EN),
        .I         (I),
        .LOAD      (LOAD),
        .PATTERN   (PATTERN),
        .LEN       (LEN),
        .OVERLAP   (OVERLAP),
        .CLR_CNT   (CLR_CNT),
        .Z         (Z),
        .MATCH_CNT (MATCH_CNT),
        .CFG_ERR   (CFG_ERR),
        .ARMED     (ARMED)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // A bit presented alongside LOAD must be ignored; config ports are scrambled afterwards.
    task automatic load_cfg(input logic [7:0] p, input logic [3:0] l, input logic o);
        PATTERN = p;
        LEN     = l;
        OVERLAP = o;
        LOAD    = 1'b1;
        EN      = 1'b1;
        I       = 1'b1;
        @(negedge CLK);
        LOAD    = 1'b0;
        EN      = 1'b0;
        PATTERN = ~p;
        LEN     = 4'd0;
        OVERLAP = ~o;
    endtask

    task automatic send(input logic b, input logic en, input logic expz, input string tag);
        EN = en;
        I  = b;
        @(negedge CLK);
        check(tag, Z, expz);
        EN = 1'b0;
    endtask

    // bits[n-1] is sent first; zexp lines up bit for bit.
    task automatic stream(input logic [15:0] bits, input int n, input logic [15:0] zexp, input string tag);
        for (int k = n - 1; k >= 0; k--) begin
            send(bits[k], 1'b1, zexp[k], $sformatf("%s_z%0d", tag, n - k));
        end
    endtask

    task automatic clr_cnt();
        CLR_CNT = 1'b1;
        EN      = 1'b0;
        @(negedge CLK);
        CLR_CNT = 1'b0;
        check("clr_cnt", MATCH_CNT, 0);
    endtask

    initial begin
        RST = 1'b0; EN = 1'b1; I = 1'b1; LOAD = 1'b0;
        PATTERN = '0; LEN = '0; OVERLAP = 1'b0; CLR_CNT = 1'b0;

        @(negedge CLK);
        check("rst_z", Z, 0);
        check("rst_cnt", MATCH_CNT, 0);
        check("rst_cfg_err", CFG_ERR, 0);
        check("rst_armed", ARMED, 0);
        RST = 1'b1;
        stream(16'b111, 3, 16'b000, "idle");

        // Non-overlap 10011 over a stream with two separate occurrences.
        load_cfg(8'b0001_0011, 4'd5, 1'b0);
        check("t1_cfg_err", CFG_ERR, 0);
        check("t1_armed_load", ARMED, 0);
        stream(16'b100, 3, 16'b000, "t1a");
        check("t1_armed_b3", ARMED, 0);
        stream(16'b1, 1, 16'b0, "t1b");
        check("t1_armed_b4", ARMED, 1);
        stream(16'b1010011, 7, 16'b1000001, "t1c");
        check("t1_cnt", MATCH_CNT, 2);
        check("t1_armed_end", ARMED, 0);

        // 1010 overlapping, then reloaded non-overlapping without clearing the count.
        clr_cnt();
        load_cfg(8'b0000_1010, 4'd4, 1'b1);
        stream(16'b101010, 6, 16'b000101, "t2ov");
        check("t2_cnt_ov", MATCH_CNT, 2);
        check("t2_armed_ov", ARMED, 1);
        load_cfg(8'b0000_1010, 4'd4, 1'b0);
        check("t2_load_keeps_cnt", MATCH_CNT, 2);
        stream(16'b101010, 6, 16'b000100, "t2no");
        check("t2_cnt_no", MATCH_CNT, 3);
        check("t2_armed_no", ARMED, 0);

        // Enable gaps hold history; I toggled during gaps must not be sampled.
        clr_cnt();
        load_cfg(8'b0001_0011, 4'd5, 1'b0);
        stream(16'b100, 3, 16'b000, "t3a");
        send(1'b1, 1'b0, 1'b0, "t3_gap1");
        send(1'b0, 1'b0, 1'b0, "t3_gap2");
        send(1'b1, 1'b0, 1'b0, "t3_gap3");
        stream(16'b11, 2, 16'b01, "t3b");
        check("t3_cnt", MATCH_CNT, 1);

        // Invalid lengths lock detection out until a valid reload.
        load_cfg(8'b0000_0101, 4'd9, 1'b0);
        check("t4_cfg_err9", CFG_ERR, 1);
        check("t4_armed9", ARMED, 0);
        stream(16'b101101, 6, 16'b000000, "t4bad");
        check("t4_cnt_hold", MATCH_CNT, 1);
        load_cfg(8'b0000_0101, 4'd0, 1'b0);
        check("t4_cfg_err0", CFG_ERR, 1);
        load_cfg(8'b0000_0101, 4'd3, 1'b1);
        check("t4_cfg_ok", CFG_ERR, 0);
        stream(16'b101, 3, 16'b001, "t4ok");
        check("t4_cnt", MATCH_CNT, 2);

        // LEN=1 saturation and clear-over-increment.
        clr_cnt();
        load_cfg(8'b0000_0001, 4'd1, 1'b1);
        check("t5_armed", ARMED, 1);
        for (int k = 1; k <= 5; k++) begin
            send(1'b1, 1'b1, 1'b1, $sformatf("t5_z%0d", k));
            check($sformatf("t5_cnt%0d", k), MATCH_CNT, (k > 3) ? 3 : k);
        end
        send(1'b0, 1'b1, 1'b0, "t5_zero");
        check("t5_cnt_sat", MATCH_CNT, 3);
        CLR_CNT = 1'b1;
        send(1'b1, 1'b1, 1'b1, "t5_clr_z");
        CLR_CNT = 1'b0;
        check("t5_clr_cnt", MATCH_CNT, 0);

        // Mid-stream async reset, then no detection until LOAD.
        load_cfg(8'b0000_0100, 4'd3, 1'b1);
        check("t6_load_z", Z, 0);
        stream(16'b100, 3, 16'b001, "t6a");
        check("t6_cnt_pre", MATCH_CNT, 1);
        check("t6_armed_pre", ARMED, 1);
        #2 RST = 1'b0;
        #1;
        check("t6_rst_z", Z, 0);
        check("t6_rst_cnt", MATCH_CNT, 0);
        check("t6_rst_armed", ARMED, 0);
        @(negedge CLK);
        RST = 1'b1;
        stream(16'b100100, 6, 16'b000000, "t6idle");
        check("t6_idle_armed", ARMED, 0);
        check("t6_idle_cnt", MATCH_CNT, 0);
        load_cfg(8'b0000_0100, 4'd3, 1'b1);
        stream(16'b100, 3, 16'b001, "t6b");
        check("t6_cnt_post", MATCH_CNT, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
